// File: rtl/uart_arb_pkg.sv
// Shared definitions for the 8-channel UART transmit arbiter: FSM encoding,
// channel count, select width and the default WAIT timeout.
package uart_arb_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    ACK  = 2'd3
  } state_t;

endpackage

// File: rtl/mux_8x1_nbit.sv
// Eight-input, N-bit wide combinational multiplexer.
// It routes the granted channel's byte to the UART transmitter.
module mux_8x1_nbit
  import uart_arb_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]     w0,
  input  logic [N-1:0]     w1,
  input  logic [N-1:0]     w2,
  input  logic [N-1:0]     w3,
  input  logic [N-1:0]     w4,
  input  logic [N-1:0]     w5,
  input  logic [N-1:0]     w6,
  input  logic [N-1:0]     w7,
  input  logic [SEL_W-1:0] sel,
  output logic [N-1:0]     y
);

  always_comb begin
    y = w0;
    case (sel)
      3'd0:    y = w0;
      3'd1:    y = w1;
      3'd2:    y = w2;
      3'd3:    y = w3;
      3'd4:    y = w4;
      3'd5:    y = w5;
      3'd6:    y = w6;
      3'd7:    y = w7;
      default: y = w0;
    endcase
  end

endmodule

// File: rtl/uart_tx_arbiter_8ch.sv
// Round-robin scheduler sharing one uart_tx among 8 byte sources.
// Optional WAIT watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter_8ch
  import uart_arb_pkg::*;
#(
  parameter int N = 8
`ifdef UART_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic [N-1:0]      w0,
  input  logic [N-1:0]      w1,
  input  logic [N-1:0]      w2,
  input  logic [N-1:0]      w3,
  input  logic [N-1:0]      w4,
  input  logic [N-1:0]      w5,
  input  logic [N-1:0]      w6,
  input  logic [N-1:0]      w7,
  input  logic              tx_done_tick,
  output logic [N-1:0]      tx_data,
  output logic              tx_start,
  output logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] gnt,
  output logic [NUM_CH-1:0] ack,
  output logic              busy
`ifdef UART_ARB_TIMEOUT_EN
  , output logic            timeout_err
`endif
);

  state_t              state_reg, state_next;
  logic [SEL_W-1:0]    sel_reg, sel_next;
  logic [SEL_W-1:0]    ptr_reg, ptr_next;
  logic [NUM_CH-1:0]   gnt_reg, gnt_next;
  logic [NUM_CH-1:0]   ack_reg, ack_next;
  logic [SEL_W-1:0]    pick;
  logic [NUM_CH-1:0]   pick_onehot;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                tmo_reg, tmo_next;
`endif

  // Scanning from the farthest offset down leaves the nearest requester at or after p.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_CH-1:0] r,
                                               input logic [SEL_W-1:0]  p);
    logic [SEL_W-1:0] idx;
    rr_pick = p;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = p + SEL_W'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign pick = rr_pick(req, ptr_reg);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_pick_onehot
      assign pick_onehot[gi] = (pick == SEL_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      ptr_reg   <= '0;
      gnt_reg   <= '0;
      ack_reg   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_reg   <= '0;
      tmo_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      ptr_reg   <= ptr_next;
      gnt_reg   <= gnt_next;
      ack_reg   <= ack_next;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_reg   <= cnt_next;
      tmo_reg   <= tmo_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    ptr_next   = ptr_reg;
    gnt_next   = gnt_reg;
    ack_next   = '0;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_next   = cnt_reg;
    tmo_next   = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (|req) begin
          sel_next   = pick;
          gnt_next   = pick_onehot;
          state_next = LOAD;
        end
      end
      LOAD: begin
        state_next = WAIT;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_next   = '0;
`endif
      end
      WAIT: begin
        // The completion tick takes precedence over the watchdog.
        if (tx_done_tick) begin
          state_next = ACK;
          ack_next   = gnt_reg;
          gnt_next   = '0;
          ptr_next   = sel_reg + 1'b1;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_next = ACK;
          ack_next   = gnt_reg;
          gnt_next   = '0;
          ptr_next   = sel_reg + 1'b1;
          tmo_next   = 1'b1;
          cnt_next   = cnt_reg + 1'b1;
        end else begin
          cnt_next   = cnt_reg + 1'b1;
        end
`endif
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  mux_8x1_nbit #(.N(N)) u_mux (
    .w0  (w0),
    .w1  (w1),
    .w2  (w2),
    .w3  (w3),
    .w4  (w4),
    .w5  (w5),
    .w6  (w6),
    .w7  (w7),
    .sel (sel_reg),
    .y   (tx_data)
  );

  assign sel      = sel_reg;
  assign gnt      = gnt_reg;
  assign ack      = ack_reg;
  assign tx_start = (state_reg == LOAD);
  assign busy     = (state_reg != IDLE);
`ifdef UART_ARB_TIMEOUT_EN
  assign timeout_err = tmo_reg;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter_8ch.sv
// Self-checking bench for uart_tx_arbiter_8ch against a round-robin reference model.
// Exercises the WAIT watchdog when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter_8ch;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic [7:0] w [8];
  logic       tx_done_tick;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic [7:0] ack;
  logic       busy;
`ifdef UART_ARB_TIMEOUT_EN
  logic       timeout_err;
  localparam int SINGLE_WAITS = 12;
`else
  localparam int SINGLE_WAITS = 19;
`endif

  int errors = 0;
  int checks = 0;
  int m_ptr  = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter_8ch #(
    .N(8)
`ifdef UART_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .w0           (w[0]),
    .w1           (w[1]),
    .w2           (w[2]),
    .w3           (w[3]),
    .w4           (w[4]),
    .w5           (w[5]),
    .w6           (w[6]),
    .w7           (w[7]),
    .tx_done_tick (tx_done_tick),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .sel          (sel),
    .gnt          (gnt),
    .ack          (ack),
    .busy         (busy)
`ifdef UART_ARB_TIMEOUT_EN
    , .timeout_err (timeout_err)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: first requesting channel at or after p, going round modulo 8.
  function automatic int model_pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_gnt"},   32'(gnt),      32'd0);
    check({tag, "_ack"},   32'(ack),      32'd0);
    check({tag, "_start"}, 32'(tx_start), 32'd0);
    check({tag, "_busy"},  32'(busy),     32'd0);
  endtask

  // Starts in IDLE with req set; returns in IDLE one cycle after the ack pulse.
  task automatic run_frame(input int waits, input logic [7:0] drop);
    int ch;
    ch = model_pick(req, m_ptr);
    step();
    check("load_start", 32'(tx_start), 32'd1);
    check("load_sel",   32'(sel),      32'(ch));
    check("load_gnt",   32'(gnt),      32'(1 << ch));
    check("load_data",  32'(tx_data),  32'(w[ch]));
    check("load_busy",  32'(busy),     32'd1);
    step();
    check("wait_start", 32'(tx_start), 32'd0);
    for (int i = 0; i < waits; i++) begin
      if (i == waits / 2) req = req & ~drop;
      check("wait_gnt",  32'(gnt),     32'(1 << ch));
      check("wait_data", 32'(tx_data), 32'(w[ch]));
      check("wait_ack",  32'(ack),     32'd0);
      step();
    end
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    check("ack_pulse", 32'(ack),      32'(1 << ch));
    check("ack_gnt",   32'(gnt),      32'd0);
    check("ack_busy",  32'(busy),     32'd1);
    check("ack_start", 32'(tx_start), 32'd0);
`ifdef UART_ARB_TIMEOUT_EN
    check("ack_tmo",   32'(timeout_err), 32'd0);
`endif
    m_ptr = (ch + 1) % 8;
    step();
    check("idle_ack",  32'(ack),  32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    $display("frame ch=%0d data=%02h waits=%0d", ch, w[ch], waits);
  endtask

  task automatic apply_reset(input logic [7:0] r);
    reset = 1'b1;
    req   = r;
    for (int i = 0; i < 2; i++) begin
      step();
      check_quiet("rst");
      check("rst_sel", 32'(sel), 32'd0);
    end
    reset = 1'b0;
    m_ptr = 0;
  endtask

  initial begin
    reset        = 1'b1;
    req          = 8'h00;
    tx_done_tick = 1'b0;
    for (int i = 0; i < 8; i++) w[i] = 8'($urandom);

    // All eight requesting from reset: 0,1,...,7 then 0 again
    apply_reset(8'hFF);
    for (int i = 0; i < 9; i++) run_frame(3, 8'h00);

    // Two requesters at the ends of the ring alternate 0,7,0,7
    apply_reset(8'h81);
    for (int i = 0; i < 4; i++) run_frame(2, 8'h00);

    // Single request on channel 5, then ptr must sit at 6
    w[5] = 8'hA5;
    req  = 8'h20;
    run_frame(SINGLE_WAITS, 8'h00);
    req  = 8'h61;
    run_frame(1, 8'h00);

    // Stray tx_done_tick while idle changes nothing
    req          = 8'h00;
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    check_quiet("idle_tick");
    step();
    check_quiet("idle_tick2");

    // Requester drops req mid-WAIT; transfer still completes with ack
    req = 8'h08;
    run_frame(6, 8'h08);
    check("drop_req", 32'(req), 32'd0);
    step();
    check_quiet("drop_after");

    // Reset while channel 2 is in WAIT: no ack, priority back to channel 0
    req = 8'h02;
    run_frame(1, 8'h00);
    req = 8'h04;
    step();
    check("abort_sel", 32'(sel), 32'd2);
    for (int i = 0; i < 4; i++) step();
    check("abort_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    check_quiet("abort_rst");
    check("abort_sel0", 32'(sel), 32'd0);
    reset = 1'b0;
    req   = 8'h00;
    m_ptr = 0;
    step();
    check_quiet("abort_after");
    req = 8'h09;
    run_frame(2, 8'h00);

`ifdef UART_ARB_TIMEOUT_EN
    begin
      int ch;
      req = 8'h03;
      ch  = model_pick(req, m_ptr);
      step();
      check("to_sel", 32'(sel), 32'(ch));
      step();
      for (int i = 0; i < 16; i++) begin
        check("to_wait_ack", 32'(ack),         32'd0);
        check("to_wait_err", 32'(timeout_err), 32'd0);
        step();
      end
      check("to_ack", 32'(ack),         32'(1 << ch));
      check("to_err", 32'(timeout_err), 32'd1);
      m_ptr = (ch + 1) % 8;
      step();
      check("to_err_clr", 32'(timeout_err), 32'd0);
      run_frame(2, 8'h00);
    end
`endif

    // Randomized traffic against the round-robin model
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 8; i++) w[i] = 8'($urandom);
      req = 8'($urandom_range(1, 255));
      run_frame(int'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
